// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin, packet-granular arbiter that steers one 4:1
// data mux (select s1,s0) and registers the chosen beat into a valid/ready
// output stage. A grant is held from the first beat to the "last" beat, and
// the search pointer advances past the requester that just finished.
module rr_mux_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       last,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [3:0]       in_ready,
  output logic [3:0]       gnt,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] y,
  output logic             y_last,
  output logic             y_valid,
  input  logic             y_ready
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_last_q, y_last_d;
  logic             y_valid_q, y_valid_d;

  logic             load_ok;
  logic             xfer;
  logic             pick_found;
  logic [1:0]       pick_idx;
  logic [1:0]       cand;
  logic [WIDTH-1:0] mux_data;
  logic             mux_last;

  // The output register can take a new beat when empty or being drained now.
  assign load_ok = ~y_valid_q | y_ready;

  // Only the granted requester sees ready, and only while a packet is open.
  always_comb begin
    in_ready = 4'b0000;
    if (state_q == BUSY && load_ok) begin
      in_ready = gnt_q;
    end
  end

  assign xfer = |(req & in_ready);

  // Rotating priority search starting at ptr, wrapping modulo 4.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int n = 0; n < 4; n++) begin
      cand = ptr_q + 2'(n);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Shared 4:1 datapath mux driven by the registered select.
  always_comb begin
    case (sel_q)
      2'd0:    mux_data = i0;
      2'd1:    mux_data = i1;
      2'd2:    mux_data = i2;
      default: mux_data = i3;
    endcase
    mux_last = last[sel_q];
  end

  // Next-state for arbitration FSM and output stage.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    y_d       = y_q;
    y_last_d  = y_last_q;
    y_valid_d = y_valid_q;

    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (pick_found) begin
          gnt_d   = 4'b0001 << pick_idx;
          sel_d   = pick_idx;
          state_d = BUSY;
        end
      end
      default: begin
        // Select stays on the finished requester; only the pointer moves on.
        if (xfer && mux_last) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = sel_q + 2'd1;
        end
      end
    endcase

    if (xfer) begin
      y_d       = mux_data;
      y_last_d  = mux_last;
      y_valid_d = 1'b1;
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  // State registers; reset abandons any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      ptr_q     <= 2'd0;
      y_q       <= '0;
      y_last_q  <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      y_q       <= y_d;
      y_last_q  <= y_last_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign s1      = sel_q[1];
  assign s0      = sel_q[0];
  assign y       = y_q;
  assign y_last  = y_last_q;
  assign y_valid = y_valid_q;

endmodule
